// File: rtl/beep_sfx.sv
// Buzzer sound effects: start-screen jingle, game-over jingle and in-game jump/crash tones,
// selected by game mode and driven out as a registered square wave.

module beep_sfx_osc #(
  parameter int unsigned HP_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic [HP_W-1:0] hp_m1,
  output logic            tone_q
);

  logic [HP_W-1:0] cnt_q;
  logic [HP_W-1:0] cnt_d;
  logic            tone_d;

  // Square wave toggling every hp_m1+1 cycles; clr restarts it low at phase zero.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clr) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == hp_m1) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d = cnt_q + HP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

endmodule

module beep_sfx #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned NOTE_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] gamemode,
  input  logic       sw,
  input  logic [1:0] crash,
  output logic       beep
);

  localparam int unsigned NOTE_CYC = CLK_HZ / NOTE_DIV;
  localparam int unsigned CYC_W    = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;

  localparam int unsigned HP_C5 = CLK_HZ / (2 * 523);
  localparam int unsigned HP_E5 = CLK_HZ / (2 * 659);
  localparam int unsigned HP_G5 = CLK_HZ / (2 * 784);
  localparam int unsigned HP_C6 = CLK_HZ / (2 * 1047);
  localparam int unsigned HP_G4 = CLK_HZ / (2 * 392);
  localparam int unsigned HP_E4 = CLK_HZ / (2 * 330);
  localparam int unsigned HP_C4 = CLK_HZ / (2 * 262);
  localparam int unsigned HP_JP = CLK_HZ / (2 * 880);
  localparam int unsigned HP_CR = CLK_HZ / (2 * 220);
  // 220 Hz is the lowest pitch, so it sets the tone counter width.
  localparam int unsigned HP_W  = (HP_CR > 1) ? $clog2(HP_CR) : 1;

  localparam logic [1:0] MODE_START = 2'b00;
  localparam logic [1:0] MODE_PLAY  = 2'b01;
  localparam logic [1:0] MODE_PAUSE = 2'b10;
  localparam logic [1:0] MODE_OVER  = 2'b11;

  localparam logic [2:0] ST_REST = 3'd4;
  localparam logic [1:0] OV_DONE = 2'd3;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(NOTE_CYC - 1);

  typedef enum logic [1:0] {
    FX_IDLE  = 2'd0,
    FX_JUMP  = 2'd1,
    FX_CRASH = 2'd2
  } fx_state_t;

  // Start jingle sequencer
  logic [2:0]       st_idx_q, st_idx_d;
  logic [1:0]       st_unit_q, st_unit_d;
  logic [CYC_W-1:0] st_cyc_q, st_cyc_d;
  logic             st_unit_end, st_note_end, st_clr, st_tone_q, st_tone_c;
  logic [HP_W-1:0]  st_hp_m1;

  // Game-over jingle sequencer
  logic [1:0]       ov_idx_q, ov_idx_d;
  logic             ov_unit_q, ov_unit_d;
  logic [CYC_W-1:0] ov_cyc_q, ov_cyc_d;
  logic             ov_unit_end, ov_note_end, ov_clr, ov_tone_q, ov_tone_c;
  logic [HP_W-1:0]  ov_hp_m1;

  // In-game effects
  fx_state_t        fx_state_q, fx_state_d;
  logic [1:0]       fx_unit_q, fx_unit_d;
  logic [CYC_W-1:0] fx_cyc_q, fx_cyc_d;
  logic             fx_unit_end, fx_end, fx_clr, fx_tone_q, fx_tone_c;
  logic             fx_start_jump, fx_start_crash;
  logic [1:0]       fx_last_unit;
  logic [HP_W-1:0]  fx_hp_m1;

  logic             sw_prev_q, sw_prev_d;
  logic [1:0]       crash_prev_q, crash_prev_d;
  logic             sw_rise, crash_rise;
  logic             beep_d;

  // Start jingle: C5 E5 G5 C6 one unit each, then a four-unit rest, looping.
  always_comb begin
    st_unit_end = (st_cyc_q == CYC_LAST);
    st_note_end = st_unit_end && (st_unit_q == ((st_idx_q == ST_REST) ? 2'd3 : 2'd0));
    st_idx_d    = st_idx_q;
    st_unit_d   = st_unit_q;
    st_cyc_d    = st_cyc_q;
    if (gamemode != MODE_START) begin
      st_idx_d  = '0;
      st_unit_d = '0;
      st_cyc_d  = '0;
    end else if (st_note_end) begin
      st_idx_d  = (st_idx_q == ST_REST) ? 3'd0 : st_idx_q + 3'd1;
      st_unit_d = '0;
      st_cyc_d  = '0;
    end else if (st_unit_end) begin
      st_unit_d = st_unit_q + 2'd1;
      st_cyc_d  = '0;
    end else begin
      st_cyc_d = st_cyc_q + CYC_W'(1);
    end
    st_clr = (gamemode != MODE_START) || st_note_end;
    case (st_idx_q)
      3'd0:    st_hp_m1 = HP_W'(HP_C5 - 1);
      3'd1:    st_hp_m1 = HP_W'(HP_E5 - 1);
      3'd2:    st_hp_m1 = HP_W'(HP_G5 - 1);
      default: st_hp_m1 = HP_W'(HP_C6 - 1);
    endcase
    st_tone_c = st_tone_q && (st_idx_q != ST_REST);
  end

  // Game-over jingle: G4 E4 C4 two units each, then silent until the mode changes.
  always_comb begin
    ov_unit_end = (ov_cyc_q == CYC_LAST);
    ov_note_end = ov_unit_end && ov_unit_q && (ov_idx_q != OV_DONE);
    ov_idx_d    = ov_idx_q;
    ov_unit_d   = ov_unit_q;
    ov_cyc_d    = ov_cyc_q;
    if (gamemode != MODE_OVER) begin
      ov_idx_d  = '0;
      ov_unit_d = 1'b0;
      ov_cyc_d  = '0;
    end else if (ov_idx_q != OV_DONE) begin
      if (ov_note_end) begin
        ov_idx_d  = ov_idx_q + 2'd1;
        ov_unit_d = 1'b0;
        ov_cyc_d  = '0;
      end else if (ov_unit_end) begin
        ov_unit_d = 1'b1;
        ov_cyc_d  = '0;
      end else begin
        ov_cyc_d = ov_cyc_q + CYC_W'(1);
      end
    end
    ov_clr = (gamemode != MODE_OVER) || ov_note_end;
    case (ov_idx_q)
      2'd0:    ov_hp_m1 = HP_W'(HP_G4 - 1);
      2'd1:    ov_hp_m1 = HP_W'(HP_E4 - 1);
      default: ov_hp_m1 = HP_W'(HP_C4 - 1);
    endcase
    ov_tone_c = ov_tone_q && (ov_idx_q != OV_DONE);
  end

  // Effects: jump blip on sw rising edge, crash tone on crash leaving zero; crash wins.
  always_comb begin
    sw_prev_d      = sw;
    crash_prev_d   = crash;
    sw_rise        = sw && !sw_prev_q;
    crash_rise     = (crash != 2'b00) && (crash_prev_q == 2'b00);
    fx_unit_end    = (fx_cyc_q == CYC_LAST);
    fx_last_unit   = (fx_state_q == FX_CRASH) ? 2'd2 : 2'd0;
    fx_end         = (fx_state_q != FX_IDLE) && fx_unit_end && (fx_unit_q == fx_last_unit);
    fx_start_crash = (gamemode == MODE_PLAY) && crash_rise;
    fx_start_jump  = (gamemode == MODE_PLAY) && sw_rise && !crash_rise && (fx_state_q != FX_CRASH);
    fx_state_d     = fx_state_q;
    fx_unit_d      = fx_unit_q;
    fx_cyc_d       = fx_cyc_q;
    if ((gamemode != MODE_PLAY) || fx_end) begin
      fx_state_d = FX_IDLE;
      fx_unit_d  = '0;
      fx_cyc_d   = '0;
    end else if (fx_start_crash) begin
      fx_state_d = FX_CRASH;
      fx_unit_d  = '0;
      fx_cyc_d   = '0;
    end else if (fx_start_jump) begin
      fx_state_d = FX_JUMP;
      fx_unit_d  = '0;
      fx_cyc_d   = '0;
    end else if (fx_state_q != FX_IDLE) begin
      if (fx_unit_end) begin
        fx_unit_d = fx_unit_q + 2'd1;
        fx_cyc_d  = '0;
      end else begin
        fx_cyc_d = fx_cyc_q + CYC_W'(1);
      end
    end
    fx_clr    = (gamemode != MODE_PLAY) || fx_start_crash || fx_start_jump || fx_end;
    fx_hp_m1  = (fx_state_q == FX_CRASH) ? HP_W'(HP_CR - 1) : HP_W'(HP_JP - 1);
    fx_tone_c = fx_tone_q && (fx_state_q != FX_IDLE);
  end

  always_comb begin
    beep_d = 1'b0;
    case (gamemode)
      MODE_START: beep_d = st_tone_c;
      MODE_PLAY:  beep_d = fx_tone_c;
      MODE_PAUSE: beep_d = 1'b0;
      MODE_OVER:  beep_d = ov_tone_c;
      default:    beep_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_idx_q     <= '0;
      st_unit_q    <= '0;
      st_cyc_q     <= '0;
      ov_idx_q     <= '0;
      ov_unit_q    <= 1'b0;
      ov_cyc_q     <= '0;
      fx_state_q   <= FX_IDLE;
      fx_unit_q    <= '0;
      fx_cyc_q     <= '0;
      sw_prev_q    <= 1'b0;
      crash_prev_q <= 2'b00;
      beep         <= 1'b0;
    end else begin
      st_idx_q     <= st_idx_d;
      st_unit_q    <= st_unit_d;
      st_cyc_q     <= st_cyc_d;
      ov_idx_q     <= ov_idx_d;
      ov_unit_q    <= ov_unit_d;
      ov_cyc_q     <= ov_cyc_d;
      fx_state_q   <= fx_state_d;
      fx_unit_q    <= fx_unit_d;
      fx_cyc_q     <= fx_cyc_d;
      sw_prev_q    <= sw_prev_d;
      crash_prev_q <= crash_prev_d;
      beep         <= beep_d;
    end
  end

  beep_sfx_osc #(.HP_W(HP_W)) u_st_osc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (st_clr),
    .hp_m1  (st_hp_m1),
    .tone_q (st_tone_q)
  );

  beep_sfx_osc #(.HP_W(HP_W)) u_ov_osc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ov_clr),
    .hp_m1  (ov_hp_m1),
    .tone_q (ov_tone_q)
  );

  beep_sfx_osc #(.HP_W(HP_W)) u_fx_osc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (fx_clr),
    .hp_m1  (fx_hp_m1),
    .tone_q (fx_tone_q)
  );

endmodule

// File: tb/tb_beep_sfx.sv
// Bench for beep_sfx: cycle-by-cycle comparison against a time-offset model of the
// jingles and effects, with a scaled-down clock so full melodies fit in a short run.

module tb_beep_sfx;

  localparam int unsigned CLK_HZ   = 16_000;
  localparam int unsigned NOTE_DIV = 16;
  localparam int          NC       = int'(CLK_HZ / NOTE_DIV);

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] gamemode;
  logic       sw;
  logic [1:0] crash;
  logic       beep;

  beep_sfx #(.CLK_HZ(CLK_HZ), .NOTE_DIV(NOTE_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gamemode (gamemode),
    .sw       (sw),
    .crash    (crash),
    .beep     (beep)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state: cycles elapsed since each generator (re)started, and the active effect.
  int         st_t, ov_t, fx_kind, fx_t;
  logic       m_sw_prev;
  logic [1:0] m_crash_prev;

  function automatic int hp(input int f);
    return int'(CLK_HZ) / (2 * f);
  endfunction

  function automatic logic sq(input int t, input int f);
    return ((t / hp(f)) % 2) == 1;
  endfunction

  function automatic logic start_ref(input int t);
    int pos;
    int f;
    pos = t % (8 * NC);
    if (pos >= 4 * NC) return 1'b0;
    case (pos / NC)
      0:       f = 523;
      1:       f = 659;
      2:       f = 784;
      default: f = 1047;
    endcase
    return sq(pos % NC, f);
  endfunction

  function automatic logic over_ref(input int t);
    int f;
    if (t >= 6 * NC) return 1'b0;
    case (t / (2 * NC))
      0:       f = 392;
      1:       f = 330;
      default: f = 262;
    endcase
    return sq(t % (2 * NC), f);
  endfunction

  function automatic logic fx_ref();
    if (fx_kind == 1) return sq(fx_t, 880);
    if (fx_kind == 2) return sq(fx_t, 220);
    return 1'b0;
  endfunction

  task automatic model_reset();
    st_t         = 0;
    ov_t         = 0;
    fx_kind      = 0;
    fx_t         = 0;
    m_sw_prev    = 1'b0;
    m_crash_prev = 2'b00;
  endtask

  // One clock: predict next beep from current inputs, clock, then advance the model.
  task automatic tick(output logic exp);
    logic [1:0] gm_s;
    logic       sw_s;
    logic [1:0] cr_s;
    logic       swr, crr;
    gm_s = gamemode;
    sw_s = sw;
    cr_s = crash;
    case (gm_s)
      2'b00:   exp = start_ref(st_t);
      2'b01:   exp = fx_ref();
      2'b10:   exp = 1'b0;
      default: exp = over_ref(ov_t);
    endcase
    swr = sw_s && !m_sw_prev;
    crr = (cr_s != 2'b00) && (m_crash_prev == 2'b00);
    @(posedge clk);
    #1;
    cyc++;
    st_t = (gm_s == 2'b00) ? st_t + 1 : 0;
    ov_t = (gm_s == 2'b11) ? ov_t + 1 : 0;
    if (gm_s != 2'b01) begin
      fx_kind = 0;
    end else if (crr) begin
      fx_kind = 2;
      fx_t    = 0;
    end else if (swr && fx_kind != 2) begin
      fx_kind = 1;
      fx_t    = 0;
    end else if (fx_kind != 0) begin
      fx_t++;
      if (fx_t >= ((fx_kind == 2) ? 3 * NC : NC)) fx_kind = 0;
    end
    m_sw_prev    = sw_s;
    m_crash_prev = cr_s;
  endtask

  task automatic test_reset();
    logic e;
    int   low_run, high_run;
    logic seen_high, done;
    rst_n    = 1'b0;
    gamemode = 2'b00;
    sw       = 1'b0;
    crash    = 2'b00;
    #23;
    n_vec++;
    if (beep !== 1'b0) begin
      n_err++;
      $display("FAIL reset_value beep=%b expected=0", beep);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    low_run   = 1;
    high_run  = 0;
    seen_high = 1'b0;
    done      = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(e);
      n_vec++;
      if (beep !== e) begin
        n_err++;
        $display("FAIL reset_first_note cyc=%0d beep=%b expected=%b", cyc, beep, e);
      end
      if (!done) begin
        if (beep === 1'b0 && !seen_high) low_run++;
        else if (beep === 1'b1) begin
          seen_high = 1'b1;
          high_run++;
        end else done = 1'b1;
      end
    end
    n_vec++;
    if (low_run != hp(523) + 1) begin
      n_err++;
      $display("FAIL first_low_run got=%0d expected=%0d", low_run, hp(523) + 1);
    end
    n_vec++;
    if (high_run != hp(523)) begin
      n_err++;
      $display("FAIL first_high_run got=%0d expected=%0d", high_run, hp(523));
    end
  endtask

  task automatic test_start_melody();
    logic e;
    for (int i = 0; i < 10 * NC - 200; i++) begin
      if ($urandom_range(0, 99) == 0) sw = ~sw;
      tick(e);
      n_vec++;
      if (beep !== e) begin
        n_err++;
        $display("FAIL start_melody cyc=%0d beep=%b expected=%b", cyc, beep, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic e;
    int   waited;
    gamemode = 2'b00;
    waited   = 0;
    while (beep !== 1'b1 && waited < 100) begin
      tick(e);
      waited++;
      n_vec++;
      if (beep !== e) begin
        n_err++;
        $display("FAIL async_pre cyc=%0d beep=%b expected=%b", cyc, beep, e);
      end
    end
    n_vec++;
    if (beep !== 1'b1) begin
      n_err++;
      $display("FAIL async_find_high beep=%b expected=1", beep);
    end
    #2;
    rst_n    = 1'b0;
    gamemode = 2'b01;
    sw       = 1'b1;
    #1;
    n_vec++;
    if (beep !== 1'b0) begin
      n_err++;
      $display("FAIL async_clear beep=%b expected=0", beep);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 300; i++) begin
      tick(e);
      n_vec++;
      if (beep !== e) begin
        n_err++;
        $display("FAIL sw_through_reset cyc=%0d beep=%b expected=%b", cyc, beep, e);
      end
    end
  endtask

  task automatic test_game_over();
    logic e;
    sw = 1'b0;
    for (int i = 0; i < 6 * NC + 720; i++) begin
      if (i < 6 * NC + 300) gamemode = 2'b11;
      else if (i < 6 * NC + 320) gamemode = 2'b00;
      else gamemode = 2'b11;
      tick(e);
      n_vec++;
      if (beep !== e) begin
        n_err++;
        $display("FAIL game_over cyc=%0d beep=%b expected=%b", cyc, beep, e);
      end
    end
  endtask

  task automatic test_jump();
    logic e;
    gamemode = 2'b01;
    sw       = 1'b0;
    crash    = 2'b00;
    for (int i = 0; i < 2 * NC + 1500; i++) begin
      if (i == 10) sw = 1'b1;
      else if (i == 13) sw = 1'b0;
      else if (i == 10 + NC / 2) sw = 1'b1;
      else if (i == 12 + NC / 2) sw = 1'b0;
      else if (i > 2 * NC && $urandom_range(0, 199) == 0) sw = ~sw;
      tick(e);
      n_vec++;
      if (beep !== e) begin
        n_err++;
        $display("FAIL jump cyc=%0d beep=%b expected=%b", cyc, beep, e);
      end
    end
  endtask

  task automatic test_crash();
    logic e;
    gamemode = 2'b01;
    sw       = 1'b0;
    crash    = 2'b00;
    for (int i = 0; i < 3 * NC + 1000; i++) begin
      if (i == 5) sw = 1'b1;
      else if (i == 205) crash = 2'b01;
      else if (i > 205 && i < 3 * NC + 300 && $urandom_range(0, 19) == 0) sw = ~sw;
      else if (i == 3 * NC + 300) crash = 2'b00;
      else if (i == 3 * NC + 310) crash = 2'b10;
      else if (i == 3 * NC + 600) crash = 2'b11;
      tick(e);
      n_vec++;
      if (beep !== e) begin
        n_err++;
        $display("FAIL crash cyc=%0d beep=%b expected=%b", cyc, beep, e);
      end
    end
    crash = 2'b00;
  endtask

  task automatic test_pause();
    logic e;
    gamemode = 2'b01;
    sw       = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (i == 5) sw = 1'b1;
      else if (i == 105) gamemode = 2'b10;
      else if (i == 130) sw = 1'b0;
      else if (i == 135) sw = 1'b1;
      else if (i == 155) gamemode = 2'b01;
      else if (i == 455) sw = 1'b0;
      else if (i == 460) sw = 1'b1;
      tick(e);
      n_vec++;
      if (beep !== e) begin
        n_err++;
        $display("FAIL pause cyc=%0d beep=%b expected=%b", cyc, beep, e);
      end
    end
  endtask

  task automatic test_random();
    logic e;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 399) == 0) gamemode = 2'($urandom);
      if ($urandom_range(0, 39) == 0) sw = ~sw;
      if ($urandom_range(0, 299) == 0) crash = 2'($urandom);
      tick(e);
      n_vec++;
      if (beep !== e) begin
        n_err++;
        $display("FAIL random cyc=%0d gm=%b beep=%b expected=%b", cyc, gamemode, beep, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_melody();
    test_async_reset();
    test_game_over();
    test_jump();
    test_crash();
    test_pause();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
